// File: rtl/radar_sched_pkg.sv
// radar_sched_pkg: scheduler state encoding, metres-per-cycle scale and default timing parameters
package radar_sched_pkg;
  typedef enum logic [2:0] {IDLE, PULSE, LISTEN, REPORT, COOLDOWN} state_e;
  localparam int unsigned METRES_PER_CYCLE = 150;
  localparam int unsigned PULSE_CYCLES_DEF = 300;
  localparam int unsigned LISTEN_MAX_DEF = 2000;
  localparam int unsigned COOLDOWN_CYCLES_DEF = 100;
endpackage

// File: rtl/radar_scheduler_rr_arbiter.sv
// rr_arbiter: 3-way round-robin pick (req_i levels, last_i one-hot last grant -> gnt_o one-hot next grant)
module rr_arbiter (
  input  logic [2:0] req_i,
  input  logic [2:0] last_i,
  output logic [2:0] gnt_o
);
  logic [2:0] p0, p1, p2;
  assign p0 = last_i[0] ? 3'b010 : last_i[1] ? 3'b100 : 3'b001;
  assign p1 = {p0[1:0], p0[2]};
  assign p2 = {p1[1:0], p1[2]};
  assign gnt_o = |(req_i & p0) ? p0 : |(req_i & p1) ? p1 : |(req_i & p2) ? p2 : 3'b000;
endmodule

// File: rtl/radar_scheduler.sv
// radar_scheduler: shares one radar between 3 requesters (req/radar_echo in; radar_pulse_trigger, grant, busy, result_* out)
module radar_scheduler
  import radar_sched_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES    = PULSE_CYCLES_DEF,
  parameter int unsigned LISTEN_MAX      = LISTEN_MAX_DEF,
  parameter int unsigned COOLDOWN_CYCLES = COOLDOWN_CYCLES_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [2:0]  req,
  input  logic        radar_echo,
  output logic        radar_pulse_trigger,
  output logic [2:0]  grant,
  output logic        busy,
  output logic        result_valid,
  output logic [1:0]  result_id,
  output logic [31:0] result_distance,
  output logic        result_timeout
);
  state_e state_q, state_d;
  logic [31:0] cnt_q, cnt_d, dist_q, dist_d;
  logic [2:0] grant_q, grant_d, last_q, last_d, next_grant;
  logic [1:0] id_q, id_d;
  logic echo_q, to_q, to_d, echo_rise;
  rr_arbiter u_arb (
    .req_i (req),
    .last_i(last_q),
    .gnt_o (next_grant)
  );
  assign echo_rise = radar_echo & ~echo_q;
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dist_q  <= '0;
      grant_q <= '0;
      last_q  <= 3'b100;
      id_q    <= '0;
      to_q    <= 1'b0;
      echo_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dist_q  <= dist_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      id_q    <= id_d;
      to_q    <= to_d;
      echo_q  <= radar_echo;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 32'd1;
    dist_d  = dist_q;
    grant_d = grant_q;
    last_d  = last_q;
    id_d    = id_q;
    to_d    = to_q;
    case (state_q)
      IDLE: begin
        cnt_d = 32'd1;
        if (req != 3'b000) begin
          state_d = PULSE;
          grant_d = next_grant;
          last_d  = next_grant;
        end
      end
      PULSE: if (cnt_q == PULSE_CYCLES) begin
        state_d = LISTEN;
        cnt_d   = 32'd1;
      end
      LISTEN: if (echo_rise || cnt_q == LISTEN_MAX) begin
        state_d = REPORT;
        id_d    = {grant_q[2], grant_q[1]};
        to_d    = ~echo_rise;
        dist_d  = echo_rise ? cnt_q * METRES_PER_CYCLE : 32'd0;
      end
      REPORT: begin
        state_d = COOLDOWN;
        grant_d = '0;
        cnt_d   = 32'd1;
      end
      COOLDOWN: if (cnt_q == COOLDOWN_CYCLES) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign radar_pulse_trigger = state_q == PULSE;
  assign busy = state_q != IDLE;
  assign result_valid = state_q == REPORT;
  assign grant = grant_q;
  assign result_id = id_q;
  assign result_distance = dist_q;
  assign result_timeout = to_q;
endmodule

// File: tb/tb_radar_scheduler.sv
// tb_radar_scheduler: directed and random transactions checked against a transaction-level model
`timescale 1ns/1ps
module tb_radar_scheduler;
  localparam int PC = 3;
  localparam int LM = 20;
  localparam int CC = 2;
  logic CLK, RST, radar_echo, radar_pulse_trigger, busy, result_valid, result_timeout;
  logic [2:0] req, grant;
  logic [1:0] result_id;
  logic [31:0] result_distance;
  int n_cmp = 0;
  int n_err = 0;
  int last_idx = 2;
  radar_scheduler #(.PULSE_CYCLES(PC), .LISTEN_MAX(LM), .COOLDOWN_CYCLES(CC)) dut (
    .CLK(CLK), .RST(RST), .req(req), .radar_echo(radar_echo),
    .radar_pulse_trigger(radar_pulse_trigger), .grant(grant), .busy(busy),
    .result_valid(result_valid), .result_id(result_id),
    .result_distance(result_distance), .result_timeout(result_timeout)
  );
  initial CLK = 1'b0;
  always #500 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [2:0] pick(input logic [2:0] r);
    logic [2:0] sh;
    for (int s = 1; s <= 3; s++) begin
      int i;
      i = (last_idx + s) % 3;
      sh = 3'b001 << i;
      if ((r & sh) != 3'b000) begin
        last_idx = i;
        return sh;
      end
    end
    return 3'b000;
  endfunction
  function automatic logic echo_at(input int n, input int k, input bit pre_high, input int hold);
    return (n >= k) || (pre_high && n <= hold);
  endfunction
  task automatic chk_all_zero(input string tag);
    chk({tag, "_trig"}, {31'd0, radar_pulse_trigger}, 0);
    chk({tag, "_grant"}, {29'd0, grant}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_rv"}, {31'd0, result_valid}, 0);
    chk({tag, "_id"}, {30'd0, result_id}, 0);
    chk({tag, "_dist"}, result_distance, 0);
    chk({tag, "_to"}, {31'd0, result_timeout}, 0);
  endtask
  task automatic txn(input logic [2:0] r, input logic [2:0] r_mid, input int k, input bit pre_high, input int hold);
    logic [2:0] g;
    int n_end, eid;
    bit prev, cur, eto;
    logic [31:0] edist;
    g = pick(r);
    eid = last_idx;
    n_end = 0;
    prev = pre_high;
    for (int n = 1; n <= LM; n++) begin
      cur = echo_at(n, k, pre_high, hold);
      if (n_end == 0 && cur && !prev) n_end = n;
      prev = cur;
    end
    eto = (n_end == 0);
    edist = eto ? 32'd0 : 32'(n_end * 150);
    if (eto) n_end = LM;
    req = r;
    @(negedge CLK);
    for (int p = 1; p <= PC; p++) begin
      chk("pulse_trig", {31'd0, radar_pulse_trigger}, 1);
      chk("pulse_grant", {29'd0, grant}, {29'd0, g});
      chk("pulse_busy", {31'd0, busy}, 1);
      chk("pulse_rv", {31'd0, result_valid}, 0);
      if (p == 1) req = r_mid;
      radar_echo = (p == PC) ? pre_high : 1'($urandom_range(0, 1));
      @(negedge CLK);
    end
    for (int n = 1; n <= n_end; n++) begin
      chk("listen_trig", {31'd0, radar_pulse_trigger}, 0);
      chk("listen_grant", {29'd0, grant}, {29'd0, g});
      chk("listen_busy", {31'd0, busy}, 1);
      chk("listen_rv", {31'd0, result_valid}, 0);
      radar_echo = echo_at(n, k, pre_high, hold);
      @(negedge CLK);
    end
    chk("report_rv", {31'd0, result_valid}, 1);
    chk("report_id", {30'd0, result_id}, 32'(eid));
    chk("report_dist", result_distance, edist);
    chk("report_to", {31'd0, result_timeout}, {31'd0, eto});
    chk("report_grant", {29'd0, grant}, {29'd0, g});
    chk("report_busy", {31'd0, busy}, 1);
    radar_echo = 1'($urandom_range(0, 1));
    @(negedge CLK);
    for (int c = 1; c <= CC; c++) begin
      chk("cool_grant", {29'd0, grant}, 0);
      chk("cool_busy", {31'd0, busy}, 1);
      chk("cool_rv", {31'd0, result_valid}, 0);
      chk("cool_dist_hold", result_distance, edist);
      chk("cool_id_hold", {30'd0, result_id}, 32'(eid));
      radar_echo = 1'($urandom_range(0, 1));
      @(negedge CLK);
    end
    chk("idle_busy", {31'd0, busy}, 0);
    chk("idle_grant", {29'd0, grant}, 0);
    chk("idle_trig", {31'd0, radar_pulse_trigger}, 0);
    req = 3'b000;
    radar_echo = 1'b0;
  endtask
  initial begin
    logic [2:0] g;
    RST = 1'b0;
    req = 3'b000;
    radar_echo = 1'b0;
    repeat (2) @(negedge CLK);
    chk_all_zero("reset");
    RST = 1'b1;
    @(negedge CLK);
    chk("idle_noreq_busy", {31'd0, busy}, 0);
    for (int t = 0; t < 4; t++) txn(3'b111, 3'b111, 4 + t, 1'b0, 0);
    txn(3'b001, 3'b000, 10, 1'b0, 0);
    txn(3'b010, 3'b000, LM + 5, 1'b0, 0);
    g = pick(3'b010);
    req = 3'b010;
    @(negedge CLK);
    chk("rst_pre_grant", {29'd0, grant}, {29'd0, g});
    req = 3'b000;
    repeat (PC + 6) @(negedge CLK);
    chk("rst_pre_busy", {31'd0, busy}, 1);
    #200 RST = 1'b0;
    #1 chk_all_zero("async_rst");
    @(posedge CLK);
    #1 chk("rst_hold_rv", {31'd0, result_valid}, 0);
    @(negedge CLK);
    RST = 1'b1;
    last_idx = 2;
    txn(3'b110, 3'b000, 8, 1'b0, 0);
    txn(3'b001, 3'b000, 5, 1'b1, 2);
    txn(3'b001, 3'b100, 12, 1'b0, 0);
    txn(3'b100, 3'b000, 3, 1'b0, 0);
    txn(3'b011, 3'b000, LM, 1'b0, 0);
    txn(3'b101, 3'b000, 1, 1'b0, 0);
    for (int t = 0; t < 25; t++)
      txn(3'($urandom_range(1, 7)), 3'($urandom_range(0, 7)), $urandom_range(1, LM + 3),
          1'($urandom_range(0, 1)), $urandom_range(1, LM));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
